// File: rtl/score_reader.sv
// Reads a two-digit score from multiplexed 7-segment lines: debounces each digit
// slot, commits stable digits, and tracks link health (idle / locked / stale).
module score_reader #(
  parameter int STABLE_COUNT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  input  logic [1:0] digits,
  input  logic       invert,
  input  logic       clr_err,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [6:0] score_bin,
  output logic       score_valid,
  output logic       blank,
  output logic       changed,
  output logic       err_pattern,
  output logic       err_select,
  output logic       locked,
  output logic [1:0] state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOCKED = 2'd1, STALE = 2'd2} state_t;

  localparam logic [3:0]  N = 4'(STABLE_COUNT);
  localparam logic [15:0] T = 16'(TIMEOUT);

  // Input stage; clr_err rides along so error events and clears stay cycle-aligned.
  logic [6:0] seg_q;
  logic [1:0] dig_q;
  logic       inv_q, clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
      dig_q <= '0;
      inv_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      seg_q <= segments;
      dig_q <= digits;
      inv_q <= invert;
      clr_q <= clr_err;
    end
  end

  logic [6:0] seg_n;
  logic [1:0] dig_n;
  assign seg_n = inv_q ? ~seg_q : seg_q;
  assign dig_n = inv_q ? ~dig_q : dig_q;

  logic [3:0] code;
  logic       code_ok;
  always_comb begin
    code    = 4'd15;
    code_ok = 1'b1;
    case (seg_n)
      7'b0111111: code = 4'd0;
      7'b0000110: code = 4'd1;
      7'b1011011: code = 4'd2;
      7'b1001111: code = 4'd3;
      7'b1100110: code = 4'd4;
      7'b1101101: code = 4'd5;
      7'b1111101: code = 4'd6;
      7'b0000111: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1101111: code = 4'd9;
      7'b0000000: code = 4'd15;
      default:    code_ok = 1'b0;
    endcase
  end

  // Slot index 0 = ones, 1 = tens.
  logic [1:0] sample;
  logic       valid_sel;
  assign sample    = {dig_n == 2'b10, dig_n == 2'b01};
  assign valid_sel = sample[0] | sample[1];

  logic [3:0] cand [2];
  logic [3:0] cnt [2];
  logic [3:0] cand_n [2];
  logic [3:0] cnt_n [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cand_n[i] = cand[i];
      cnt_n[i]  = cnt[i];
      if (sample[i]) begin
        if (!code_ok) begin
          cnt_n[i] = 4'd0;
        end else if (code == cand[i]) begin
          cnt_n[i] = (cnt[i] == N) ? cnt[i] : cnt[i] + 4'd1;
        end else begin
          cand_n[i] = code;
          cnt_n[i]  = 4'd1;
        end
      end
    end
  end

  // Match stage: every sample that leaves a slot at full count requests a commit.
  logic [1:0]  pend;
  logic [3:0]  pval [2];
  logic [15:0] stale_cnt;
  logic        pat_ev, sel_ev, clr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cand[i] <= 4'd15;
        cnt[i]  <= 4'd0;
        pval[i] <= 4'd15;
      end
      pend      <= '0;
      stale_cnt <= '0;
      pat_ev    <= 1'b0;
      sel_ev    <= 1'b0;
      clr_d     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cand[i] <= cand_n[i];
        cnt[i]  <= cnt_n[i];
        pend[i] <= sample[i] && code_ok && (cnt_n[i] == N);
        pval[i] <= code;
      end
      if (valid_sel)
        stale_cnt <= '0;
      else if (stale_cnt != T)
        stale_cnt <= stale_cnt + 16'd1;
      pat_ev <= valid_sel && !code_ok;
      sel_ev <= (dig_n == 2'b11);
      clr_d  <= clr_q;
    end
  end

  logic [3:0] ones_n, tens_n;
  logic       pair_diff;
  assign ones_n    = pend[0] ? pval[0] : ones;
  assign tens_n    = pend[1] ? pval[1] : tens;
  assign pair_diff = {tens_n, ones_n} != {tens, ones};

  state_t     state;
  logic [1:0] seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ones        <= 4'd15;
      tens        <= 4'd15;
      seen        <= '0;
      changed     <= 1'b0;
      err_pattern <= 1'b0;
      err_select  <= 1'b0;
    end else begin
      ones        <= ones_n;
      tens        <= tens_n;
      seen        <= seen | pend;
      changed     <= 1'b0;
      err_pattern <= (err_pattern & ~clr_d) | pat_ev;
      err_select  <= (err_select & ~clr_d) | sel_ev;
      case (state)
        IDLE: begin
          if ((seen[0] | pend[0]) && (seen[1] | pend[1]))
            state <= LOCKED;
        end
        LOCKED: begin
          if (stale_cnt == T)
            state <= STALE;
          else
            changed <= pair_diff;
        end
        STALE: begin
          if (pend != 2'b00) begin
            state   <= LOCKED;
            changed <= pair_diff;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign locked      = (state == LOCKED);
  assign state_dbg   = state;
  assign score_valid = locked && (ones <= 4'd9) && (tens <= 4'd9);
  assign blank       = locked && (ones == 4'd15) && (tens == 4'd15);
  assign score_bin   = score_valid ? 7'({3'b000, tens} * 7'd10 + {3'b000, ones}) : 7'd0;
endmodule

// File: tb/tb_score_reader.sv
// Randomized bench for score_reader: a slot-history reference model predicts every
// output cycle; a monitor compares the DUT two edges after each stimulus cycle.
module tb_score_reader;
  localparam int N = 4;
  localparam int T = 64;
  localparam logic [20:0] RST_EXP = {4'hF, 4'hF, 7'd0, 6'b000000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segments = '0;
  logic [1:0] digits = '0;
  logic       invert = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] ones, tens;
  logic [6:0] score_bin;
  logic       score_valid, blank, changed, err_pattern, err_select, locked;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  score_reader #(.STABLE_COUNT(N), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .segments(segments), .digits(digits), .invert(invert),
    .clr_err(clr_err), .ones(ones), .tens(tens), .score_bin(score_bin),
    .score_valid(score_valid), .blank(blank), .changed(changed),
    .err_pattern(err_pattern), .err_select(err_select), .locked(locked),
    .state_dbg(state_dbg)
  );

  logic [20:0] got;
  assign got = {ones, tens, score_bin, score_valid, blank, changed, err_pattern, err_select, locked};

  logic [20:0] exp_q[$];
  int          tag_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // Reference model: last N samples per slot, link mode 0 idle / 1 locked / 2 stale.
  int m_ones, m_tens, m_mode, m_run;
  bit m_seen [2];
  bit m_ep, m_es;
  int last [2][N];
  int fill [2];

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == seg_tab[i]) return i;
    if (s == 7'd0) return 15;
    return -1;
  endfunction

  function automatic logic [6:0] enc(input int d);
    if (d == 15) return 7'd0;
    return seg_tab[d];
  endfunction

  task automatic check(input string name, input logic [20:0] g, input logic [20:0] e, input int tag);
    n_checks++;
    if (g === e) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, tag, g, e);
  endtask

  task automatic model_reset();
    m_ones = 15; m_tens = 15; m_mode = 0; m_run = 0;
    m_seen[0] = 0; m_seen[1] = 0; m_ep = 0; m_es = 0;
    fill[0] = 0; fill[1] = 0;
  endtask

  task automatic model_step(input logic [6:0] seg, input logic [1:0] dig, input bit inv, input bit clr);
    logic [6:0] s, sb;
    logic [1:0] d;
    int c, po, pt, prev;
    bit commit [2];
    bit valid, sv, bl, ch, all_eq;
    s = inv ? ~seg : seg;
    d = inv ? ~dig : dig;
    c = dec(s);
    for (int k = 0; k < 2; k++) begin
      commit[k] = 0;
      if (d == ((k == 0) ? 2'b01 : 2'b10)) begin
        for (int j = N - 1; j > 0; j--) last[k][j] = last[k][j-1];
        last[k][0] = c;
        if (fill[k] < N) fill[k]++;
        all_eq = (fill[k] == N) && (c >= 0);
        for (int j = 1; j < N; j++) if (last[k][j] != c) all_eq = 0;
        commit[k] = all_eq;
      end
    end
    valid = (d == 2'b01) || (d == 2'b10);
    m_run = valid ? 0 : ((m_run < T) ? m_run + 1 : m_run);
    m_ep  = (m_ep && !clr) || (valid && c < 0);
    m_es  = (m_es && !clr) || (d == 2'b11);
    po = m_ones; pt = m_tens; prev = m_mode;
    if (commit[0]) begin m_ones = c; m_seen[0] = 1; end
    if (commit[1]) begin m_tens = c; m_seen[1] = 1; end
    case (m_mode)
      0: if (m_seen[0] && m_seen[1]) m_mode = 1;
      1: if (m_run >= T) m_mode = 2;
      default: if (commit[0] || commit[1]) m_mode = 1;
    endcase
    ch = (prev != 0) && (m_mode == 1) && (po != m_ones || pt != m_tens);
    sv = (m_mode == 1) && (m_ones <= 9) && (m_tens <= 9);
    bl = (m_mode == 1) && (m_ones == 15) && (m_tens == 15);
    sb = sv ? 7'(m_tens * 10 + m_ones) : 7'd0;
    exp_q.push_back({4'(m_ones), 4'(m_tens), sb, sv, bl, ch, m_ep, m_es, m_mode == 1});
    tag_q.push_back(cyc);
    cyc++;
  endtask

  task automatic apply_now(input logic [6:0] seg, input logic [1:0] dig, input bit inv, input bit clr);
    segments = seg; digits = dig; invert = inv; clr_err = clr;
    model_step(seg, dig, inv, clr);
  endtask

  task automatic drive(input logic [6:0] seg, input logic [1:0] dig, input bit inv, input bit clr);
    @(negedge clk);
    apply_now(seg, dig, inv, clr);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; segments = '0; digits = '0; invert = 1'b0; clr_err = 1'b0;
    repeat (n) @(negedge clk);
    check("reset", got, RST_EXP, cyc);
    rst = 1'b0;
    exp_q.delete();
    tag_q.delete();
    model_reset();
    apply_now(7'd0, 2'b00, 1'b0, 1'b0);
  endtask

  // Alternate tens then ones, complementing all lines when inv is set.
  task automatic pair(input int t, input int o, input bit inv, input int n);
    logic [6:0] s;
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      s = enc((i % 2 == 0) ? t : o);
      d = (i % 2 == 0) ? 2'b10 : 2'b01;
      drive(inv ? ~s : s, inv ? ~d : d, inv, 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit inv);
    for (int i = 0; i < n; i++)
      drive(7'($urandom), inv ? 2'b11 : 2'b00, inv, 1'b0);
  endtask

  function automatic int pick();
    int v;
    v = $urandom_range(0, 10);
    return (v == 10) ? 15 : v;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() >= 3)
      check("outputs", got, exp_q.pop_front(), tag_q.pop_front());
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, t, o, n;
    bit inv;
    logic [6:0] s;
    logic [1:0] d;
    do_reset(3);
    pair(0, 3, 1'b0, 20);
    pair(0, 4, 1'b0, 12);
    idle(T + 6, 1'b0);
    pair(0, 4, 1'b0, 12);
    do_reset(2);
    pair(0, 3, 1'b1, 20);
    drive(7'b1010101, 2'b01, 1'b0, 1'b0);
    drive(enc(0), 2'b11, 1'b0, 1'b0);
    pair(0, 3, 1'b0, 6);
    drive(7'd0, 2'b00, 1'b0, 1'b1);
    pair(0, 3, 1'b0, 6);
    drive(7'b1010101, 2'b01, 1'b0, 1'b1);
    pair(0, 3, 1'b0, 4);
    drive(7'd0, 2'b00, 1'b0, 1'b1);
    pair(15, 15, 1'b0, 14);
    pair(0, 5, 1'b0, 5);
    do_reset(2);
    pair(0, 5, 1'b0, 12);
    for (int b = 0; b < 40; b++) begin
      r = $urandom_range(0, 9);
      inv = 1'($urandom_range(0, 1));
      if (r == 0) begin
        do_reset($urandom_range(1, 3));
      end else if (r == 1) begin
        idle($urandom_range(T - 4, T + 8), inv);
      end else begin
        t = pick(); o = pick(); n = $urandom_range(4, 20);
        for (int i = 0; i < n; i++) begin
          s = enc((i % 2 == 0) ? t : o);
          d = (i % 2 == 0) ? 2'b10 : 2'b01;
          if ($urandom_range(0, 15) == 0) s = 7'($urandom);
          if ($urandom_range(0, 19) == 0) d = 2'($urandom);
          drive(inv ? ~s : s, inv ? ~d : d, inv, $urandom_range(0, 9) == 0);
        end
      end
    end
    idle(3, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/score_reader.md
SCORE_READER -- requirements
Module: score_reader

Interface
REQ-001 Parameter STABLE_COUNT, default 4: consecutive identical decodes per digit slot required before commit; legal range 2-15.
REQ-002 Parameter TIMEOUT, default 64: cycles without a valid digit select before the link is declared stale; legal range 8-65535.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 segments  input  7  multiplexed 7-segment lines {g,f,e,d,c,b,a}, bit0 = a.
REQ-006 digits  input  2  digit select; bit0 = ones, bit1 = tens.
REQ-007 invert  input  1  1 = active-low segments and digit select; sampled every cycle.
REQ-008 clr_err  input  1  single-cycle clear of the sticky error flags.
REQ-009 ones  output  4  committed ones digit, 0-9, or 15 = blank.
REQ-010 tens  output  4  committed tens digit, 0-9, or 15 = blank.
REQ-011 score_bin  output  7  tens*10+ones when score_valid, else 0.
REQ-012 score_valid  output  1  high in LOCKED with both slots 0-9.
REQ-013 blank  output  1  high in LOCKED with both slots 15.
REQ-014 changed  output  1  one-cycle pulse when the committed {tens,ones} pair changes while LOCKED.
REQ-015 err_pattern  output  1  sticky flag: undecodable segment pattern seen.
REQ-016 err_select  output  1  sticky flag: both digit lines active at once.
REQ-017 locked  output  1  high when state is LOCKED.

Function
REQ-018 segments, digits and invert SHALL be registered in one input stage; all decoding SHALL use the registered copies only.
REQ-019 When invert=1, segments and digits SHALL be bitwise inverted before decode.
REQ-020 Normalised select decode: 01 = ones slot, 10 = tens slot, 00 = no sample, 11 = no sample and set err_select.
REQ-021 Pattern decode table: 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9, 0000000=15 (blank).
REQ-022 Any other pattern on a valid slot sample SHALL set err_pattern; the slot's match counter SHALL reset to 0; nothing is committed.
REQ-023 Each slot SHALL hold a 4-bit candidate and a match counter; on a sample equal to the candidate the counter SHALL increment, saturating at STABLE_COUNT; on an unequal sample the candidate SHALL load the new code and the counter SHALL become 1.
REQ-024 When a slot's counter reaches STABLE_COUNT, the candidate SHALL be committed to ones/tens on the following edge and the slot marked seen.
REQ-025 Latency: a committed value SHALL appear 2 cycles after the pins carry the STABLE_COUNT-th matching sample.
REQ-026 State machine: IDLE -> LOCKED once both slots are seen; LOCKED -> STALE after TIMEOUT consecutive cycles with no valid select; STALE -> LOCKED on the next commit to either slot; rst -> IDLE from any state.
REQ-027 The stale counter SHALL reset on every valid select (01 or 10) and saturate at TIMEOUT.
REQ-028 In IDLE and STALE, score_valid, blank and changed SHALL be 0; ones and tens SHALL hold their last committed values.
REQ-029 changed SHALL NOT pulse on the IDLE->LOCKED transition; it SHALL pulse on STALE->LOCKED only if the pair differs from the value held before STALE.
REQ-030 A mixed blank/digit pair SHALL give score_valid=0 and blank=0.
REQ-031 If clr_err is asserted in the same cycle as a new error event, the error SHALL win and the flag SHALL remain set.
REQ-032 score_bin SHALL be computed combinationally from the committed digits; maximum value 99.

Reset
REQ-033 rst SHALL clear all of the following: input stage = 0; candidates = 15; counters = 0; ones = tens = 15; state = IDLE; all flags and outputs = 0.
REQ-034 rst asserted mid-acquisition SHALL discard all partial matches; reacquisition SHALL need STABLE_COUNT fresh samples per slot.

Verification
REQ-035 invert=0, alternate tens=0111111/10 and ones=1001111/01 every cycle -> locked=1, score_bin=3, ones=3, tens=0 by cycle 10 after rst release; changed=0.
REQ-036 Same as REQ-035 with invert=1 and all lines complemented -> identical outputs.
REQ-037 While locked at 03, change ones to 1100110 (4) -> one changed pulse; score_bin=4 exactly 2 cycles after the 4th matching ones sample.
REQ-038 Drive digits=00 for TIMEOUT=64 cycles -> locked=0 and score_valid=0 on cycle 65; resume 04 -> locked=1 with changed=0.
REQ-039 Inject a ones sample of 1010101 and one cycle of digits=11 -> err_pattern=1 and err_select=1; committed value unchanged; clr_err -> both flags 0.
REQ-040 All-blank 0000000 on both slots -> blank=1, score_valid=0, score_bin=0, ones=tens=15.
